bot_permute_collector: RTL and testbench
========================================

// Module: bot_permute_collector
// PURPOSE
//  Receive end of the bottom-permutation stream. Accepts one tagged result per cycle.
//  Tags: permutation index 0..5, extra data, end-of-burst flag. Accumulates each burst
//  into a single record (sum, seen-permutation mask, extra data, error flag). Sits
//  after the per-permutation compute pipeline and hands completed bursts downstream.
// PARAMETERS
//  EXTRA_DATA_WIDTH  12  width of per-burst tag, carried unchanged
//  RESULT_WIDTH      32  width of one per-permutation result
//  SUM_WIDTH         RESULT_WIDTH+3  accumulator width (6 terms max, no overflow possible)
// PORTS
//  clk                 in   1   single clock
//  rst                 in   1   synchronous, active-high reset
//  resultValid         in   1   result/perm/extra/last below are meaningful
//  resultIn            in   RESULT_WIDTH  result for one permutation
//  selectedPermutation in   3   index 0..5 (5=ABC,4=ACB,3=BAC,2=BCA,1=CAB,0=CBA)
//  extraDataIn         in   EXTRA_DATA_WIDTH  burst tag, constant within a burst
//  lastIn              in   1   this is the final result of the burst
//  outValid            out  1   head record available
//  outReady            in   1   downstream pops head when outValid&outReady
//  outSum              out  SUM_WIDTH  zero-extended sum of burst results
//  outSeenMask         out  6   bit k set iff permutation k received in burst
//  outExtraData        out  EXTRA_DATA_WIDTH  tag of first result of burst
//  outError            out  1   burst had duplicate index, index 6/7, or tag mismatch
//  full                out  1   output buffer holds 2 records; upstream stalls bursts
//  overflow            out  1   sticky: a record was dropped for lack of space
// BEHAVIOUR
//  - Internal reset passes through a 2-cycle hyperpipe. Inputs are ignored until it deasserts.
//  - Reset values: outValid=0, full=0, overflow=0. Accumulator=0, seenMask=0, inBurst=0.
//  - Reset values: outSum/outSeenMask/outExtraData/outError are don't-care while outValid=0.
//  - Reset mid-burst discards the partial burst and both buffered records.
//  - Accumulation applies only on cycles with resultValid=1.
//  - First valid cycle of a burst (inBurst=0): load sum=resultIn and mask=onehot(idx).
//    Also capture tag, clear error, set inBurst=1.
//  - Subsequent valid cycles: sum+=resultIn, mask|=onehot(idx).
//    error|=(mask&onehot(idx))!=0, and error|=extraDataIn!=captured tag.
//  - idx 6 or 7 with resultValid=1 sets error. No mask bit is set and resultIn is still summed.
//  - Valid with lastIn=1 completes the burst using that cycle's contribution.
//    Record is pushed to output buffer at end of that cycle, so outValid can rise next cycle.
//    Latency: last result -> record visible = 1 cycle.
//  - inBurst clears on completion. Single-element bursts (first cycle also last) are legal.
//  - Back-to-back bursts with zero idle cycles are legal.
//  - lastIn with resultValid=0 is ignored.
//  - Output buffer is a 2-entry FIFO; outValid = !empty.
//  - full = (count==2), registered.
//  - Pop and push in the same cycle are both allowed, including when count==2.
//    The pop frees the slot first.
//  - Push while count==2 with no pop: record dropped, overflow set (sticky until rst).
//    FIFO contents are unchanged.
//  - Output fields hold steady while outValid=1 and outReady=0.
// STRUCTURE
//  - Shared package/include: permutation index constants PERM_ABC..PERM_CBA = 5..0.
//  - Shared package/include: PERM_NONE = 7, and the 6-bit mask bit order.
//  - These are shared with the bottom permuter.
//  - One sub-module: collector_output_fifo (2-entry, push/pop/full/empty, width = record).
//  - Top level: reset pipe, burst accumulator regs, error logic, FIFO instance.
// TESTING
//  - Six results 1..6, idx 5..0, tag 0x0AB, last on 6th.
//    -> 1 cycle later outSum=21, outSeenMask=6'b111111, outExtraData=0x0AB, outError=0.
//  - Single result 0xFFFFFFFF, idx 2, last.
//    -> outSum=0x0FFFFFFFF, outSeenMask=6'b000100, outError=0.
//  - Burst idx 4, then idx 4 with last -> outSeenMask=6'b010000, outError=1.
//  - Burst with tag changing 0x001 -> 0x002 -> outExtraData=0x001, outError=1.
//  - outReady=0, three back-to-back single-result bursts with sums 1,2,3.
//    -> full=1 after 2nd, overflow=1 after 3rd.
//    -> then outReady=1 pops sums 1 then 2, after which outValid=0.
//  - Assert rst mid-burst after two results, then send a fresh 1-result burst of 7 with last.
//    -> outSum=7, outSeenMask has only that idx, overflow=0.

Source files
------------

// File: rtl/bot_permute_collector_pkg.sv
// Shared definitions for the bottom-permutation stream: permutation index encoding and
// seen-mask bit order, common to the bottom permuter and its collector.
package bot_permute_collector_pkg;

    localparam int unsigned EXTRA_DATA_WIDTH_DEFAULT = 12;
    localparam int unsigned RESULT_WIDTH_DEFAULT     = 32;
    localparam int unsigned PERM_COUNT               = 6;
    localparam int unsigned PERM_IDX_WIDTH           = 3;

    typedef logic [PERM_IDX_WIDTH-1:0] permIdx_t;
    // Seen-mask bit k corresponds to permutation index k.
    typedef logic [PERM_COUNT-1:0]     permMask_t;

    localparam permIdx_t PERM_ABC  = 3'd5;
    localparam permIdx_t PERM_ACB  = 3'd4;
    localparam permIdx_t PERM_BAC  = 3'd3;
    localparam permIdx_t PERM_BCA  = 3'd2;
    localparam permIdx_t PERM_CAB  = 3'd1;
    localparam permIdx_t PERM_CBA  = 3'd0;
    localparam permIdx_t PERM_NONE = 3'd7;

    function automatic logic permIsValid(input permIdx_t idx);
        return idx < permIdx_t'(PERM_COUNT);
    endfunction

    // Indices 6 and 7 map to an empty mask.
    function automatic permMask_t permOneHot(input permIdx_t idx);
        permMask_t mask;
        mask = '0;
        if (permIsValid(idx)) begin
            mask = permMask_t'(1) << idx;
        end
        return mask;
    endfunction

endpackage

// File: rtl/bot_permute_collector_if.sv
// Tagged-result input stream and completed-burst output handshake of the collector.
interface bot_permute_collector_if #(
    parameter int unsigned EXTRA_DATA_WIDTH = 12,
    parameter int unsigned RESULT_WIDTH     = 32
);
    localparam int unsigned SUM_WIDTH = RESULT_WIDTH + 3;

    logic                        resultValid;
    logic [RESULT_WIDTH-1:0]     resultIn;
    logic [2:0]                  selectedPermutation;
    logic [EXTRA_DATA_WIDTH-1:0] extraDataIn;
    logic                        lastIn;

    logic                        outValid;
    logic                        outReady;
    logic [SUM_WIDTH-1:0]        outSum;
    logic [5:0]                  outSeenMask;
    logic [EXTRA_DATA_WIDTH-1:0] outExtraData;
    logic                        outError;
    logic                        full;
    logic                        overflow;

    modport master (
        output resultValid, resultIn, selectedPermutation, extraDataIn, lastIn, outReady,
        input  outValid, outSum, outSeenMask, outExtraData, outError, full, overflow
    );

    modport slave (
        input  resultValid, resultIn, selectedPermutation, extraDataIn, lastIn, outReady,
        output outValid, outSum, outSeenMask, outExtraData, outError, full, overflow
    );

endinterface

// File: rtl/bot_permute_collector_output_fifo.sv
// Two-entry record buffer for completed bursts; a pop in the same cycle frees a slot for a push.
module collector_output_fifo #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] pushData,
    input  logic             pop,
    output logic [Width-1:0] popData,
    output logic             empty,
    output logic             full
);

    logic [Width-1:0] memQ [2];
    logic             wrPtrQ;
    logic             rdPtrQ;
    logic [1:0]       countQ;
    logic             popEff;
    logic             pushEff;

    always_comb begin
        popEff  = pop & (countQ != 2'd0);
        pushEff = push & ((countQ != 2'd2) | popEff);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtrQ <= 1'b0;
            rdPtrQ <= 1'b0;
            countQ <= 2'd0;
        end else begin
            if (pushEff) begin
                memQ[wrPtrQ] <= pushData;
                wrPtrQ       <= ~wrPtrQ;
            end
            if (popEff) begin
                rdPtrQ <= ~rdPtrQ;
            end
            countQ <= countQ + 2'(pushEff) - 2'(popEff);
        end
    end

    assign popData = memQ[rdPtrQ];
    assign empty   = (countQ == 2'd0);
    assign full    = (countQ == 2'd2);

endmodule

// File: rtl/bot_permute_collector.sv
// Collects tagged per-permutation results into one record per burst and buffers completed
// records for downstream.
module bot_permute_collector
    import bot_permute_collector_pkg::*;
#(
    parameter int unsigned EXTRA_DATA_WIDTH = EXTRA_DATA_WIDTH_DEFAULT,
    parameter int unsigned RESULT_WIDTH     = RESULT_WIDTH_DEFAULT
) (
    input logic                    clk,
    input logic                    rst,
    bot_permute_collector_if.slave bus
);

    localparam int unsigned SUM_WIDTH    = RESULT_WIDTH + 3;
    localparam int unsigned RECORD_WIDTH = SUM_WIDTH + PERM_COUNT + EXTRA_DATA_WIDTH + 1;

    // Reset is retimed through two flops so it can be placed freely.
    logic [1:0] rstPipe;
    logic       rstInt;

    always_ff @(posedge clk) begin
        rstPipe <= {rstPipe[0], rst};
    end

    assign rstInt = rstPipe[1];

    logic [SUM_WIDTH-1:0]        sumQ, sumD;
    permMask_t                   maskQ, maskD;
    logic [EXTRA_DATA_WIDTH-1:0] tagQ, tagD;
    logic                        errorQ, errorD;
    logic                        inBurstQ;
    logic                        overflowQ;

    permMask_t                   hit;
    logic                        badIdx;
    logic                        take;
    logic                        push;
    logic                        pop;
    logic [RECORD_WIDTH-1:0]     pushData;
    logic [RECORD_WIDTH-1:0]     headData;
    logic                        fifoEmpty;
    logic                        fifoFull;

    always_comb begin
        hit    = permOneHot(bus.selectedPermutation);
        badIdx = ~permIsValid(bus.selectedPermutation);
        take   = bus.resultValid & ~rstInt;

        if (inBurstQ) begin
            sumD   = sumQ + SUM_WIDTH'(bus.resultIn);
            maskD  = maskQ | hit;
            tagD   = tagQ;
            errorD = errorQ | (|(maskQ & hit)) | (bus.extraDataIn != tagQ) | badIdx;
        end else begin
            sumD   = SUM_WIDTH'(bus.resultIn);
            maskD  = hit;
            tagD   = bus.extraDataIn;
            errorD = badIdx;
        end

        // The completing cycle's contribution goes straight into the pushed record.
        push     = take & bus.lastIn;
        pushData = {sumD, maskD, tagD, errorD};
        pop      = ~fifoEmpty & bus.outReady;
    end

    always_ff @(posedge clk) begin
        if (rstInt) begin
            sumQ      <= '0;
            maskQ     <= '0;
            tagQ      <= '0;
            errorQ    <= 1'b0;
            inBurstQ  <= 1'b0;
            overflowQ <= 1'b0;
        end else begin
            if (take) begin
                sumQ     <= sumD;
                maskQ    <= maskD;
                tagQ     <= tagD;
                errorQ   <= errorD;
                inBurstQ <= ~bus.lastIn;
            end
            if (push & fifoFull & ~pop) begin
                overflowQ <= 1'b1;
            end
        end
    end

    collector_output_fifo #(
        .Width(RECORD_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rstInt),
        .push    (push),
        .pushData(pushData),
        .pop     (pop),
        .popData (headData),
        .empty   (fifoEmpty),
        .full    (fifoFull)
    );

    assign bus.outValid = ~fifoEmpty;
    assign bus.full     = fifoFull;
    assign bus.overflow = overflowQ;
    assign {bus.outSum, bus.outSeenMask, bus.outExtraData, bus.outError} = headData;

endmodule

// File: tb/tb_bot_permute_collector.sv
// Scoreboard bench for bot_permute_collector: burst records predicted from queued results.
module tb_bot_permute_collector;

    localparam int unsigned EW = 12;
    localparam int unsigned RW = 32;
    localparam int unsigned SW = RW + 3;

    typedef struct packed {
        logic [SW-1:0] sum;
        logic [5:0]    mask;
        logic [EW-1:0] extra;
        logic          err;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bot_permute_collector_if #(.EXTRA_DATA_WIDTH(EW), .RESULT_WIDTH(RW)) bus ();

    bot_permute_collector #(
        .EXTRA_DATA_WIDTH(EW),
        .RESULT_WIDTH    (RW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int            checks = 0;
    int            fails  = 0;
    rec_t          expQ[$];
    bit            modelOvf = 1'b0;
    bit            rdy = 1'b0;
    logic [RW-1:0] bRes[$];
    logic [2:0]    bIdx[$];
    logic [EW-1:0] bTag[$];

    // Record built directly from the rules: plain sum, set of seen indices, duplicates,
    // out-of-range indices and tag changes.
    function automatic rec_t modelRecord();
        rec_t r;
        int   seen[8] = '{default: 0};
        r.sum   = '0;
        r.mask  = '0;
        r.err   = 1'b0;
        r.extra = bTag[0];
        for (int i = 0; i < bRes.size(); i++) begin
            r.sum = r.sum + SW'(bRes[i]);
            seen[bIdx[i]]++;
            if (bIdx[i] > 3'd5) r.err = 1'b1;
            else r.mask = r.mask | (6'd1 << bIdx[i]);
            if (bTag[i] != bTag[0]) r.err = 1'b1;
        end
        for (int k = 0; k < 6; k++) if (seen[k] > 1) r.err = 1'b1;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [RW-1:0] res, input logic [2:0] idx,
                         input logic [EW-1:0] tag, input bit last);
        rec_t r;
        @(posedge clk);
        #1;
        bus.resultValid         = v;
        bus.resultIn            = res;
        bus.selectedPermutation = idx;
        bus.extraDataIn         = tag;
        bus.lastIn              = last;
        bus.outReady            = rdy;
        if (v) begin
            bRes.push_back(res);
            bIdx.push_back(idx);
            bTag.push_back(tag);
            if (last) begin
                r = modelRecord();
                bRes.delete();
                bIdx.delete();
                bTag.delete();
                // A pop at the same edge frees a slot; otherwise a full buffer drops it.
                if (expQ.size() == 2 && !rdy) modelOvf = 1'b1;
                else expQ.push_back(r);
            end
        end
    endtask

    task automatic idle();
        drive(1'b0, '0, 3'd0, '0, 1'b0);
    endtask

    task automatic resetDut();
        rdy = 1'b0;
        rst = 1'b1;
        expQ.delete();
        bRes.delete();
        bIdx.delete();
        bTag.delete();
        modelOvf = 1'b0;
        repeat (4) idle();
        rst = 1'b0;
        repeat (3) idle();
    endtask

    // Monitor: every handshake pops the oldest predicted record and compares it.
    always @(negedge clk) begin
        rec_t act;
        rec_t exp;
        if (bus.outValid === 1'b1 && bus.outReady === 1'b1) begin
            act = {bus.outSum, bus.outSeenMask, bus.outExtraData, bus.outError};
            checks++;
            if (expQ.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: got %h expected no record", act);
            end else begin
                exp = expQ.pop_front();
                if (act !== exp) begin
                    fails++;
                    $display("FAIL pop_record: got sum=%h mask=%b tag=%h err=%b expected sum=%h mask=%b tag=%h err=%b",
                             act.sum, act.mask, act.extra, act.err,
                             exp.sum, exp.mask, exp.extra, exp.err);
                end
            end
        end
    end

    initial begin
        int          p[6];
        int          len;
        int          j;
        int          t;
        logic [2:0]  idx;
        logic [EW-1:0] tag;

        bus.resultValid         = 1'b0;
        bus.resultIn            = '0;
        bus.selectedPermutation = '0;
        bus.extraDataIn         = '0;
        bus.lastIn              = 1'b0;
        bus.outReady            = 1'b0;

        resetDut();
        check("rst_outValid", 64'(bus.outValid), 64'd0);
        check("rst_full", 64'(bus.full), 64'd0);
        check("rst_overflow", 64'(bus.overflow), 64'd0);

        // Full six-permutation burst, one-cycle latency to visible record.
        rdy = 1'b1;
        for (int i = 0; i < 6; i++) drive(1'b1, RW'(i + 1), 3'(5 - i), 12'h0AB, i == 5);
        idle();
        check("lat_outValid", 64'(bus.outValid), 64'd1);
        check("burst6_sum", 64'(bus.outSum), 64'd21);
        check("burst6_mask", 64'(bus.outSeenMask), 64'h3F);

        drive(1'b1, 32'hFFFF_FFFF, 3'd2, 12'h055, 1'b1);
        idle();
        check("single_sum", 64'(bus.outSum), 64'h0FFFF_FFFF);

        drive(1'b1, 32'd10, 3'd4, 12'h011, 1'b0);
        drive(1'b1, 32'd20, 3'd4, 12'h011, 1'b1);
        idle();
        check("dup_error", 64'(bus.outError), 64'd1);

        drive(1'b1, 32'd3, 3'd0, 12'h001, 1'b0);
        drive(1'b1, 32'd4, 3'd1, 12'h002, 1'b1);
        idle();
        check("tag_extra", 64'(bus.outExtraData), 64'h001);
        repeat (2) idle();

        // Buffer fill and drop with downstream stalled.
        rdy = 1'b0;
        drive(1'b1, 32'd1, 3'd0, 12'h005, 1'b1);
        drive(1'b1, 32'd2, 3'd1, 12'h005, 1'b1);
        drive(1'b1, 32'd3, 3'd2, 12'h005, 1'b1);
        check("full_after2", 64'(bus.full), 64'd1);
        check("no_ovf_after2", 64'(bus.overflow), 64'd0);
        idle();
        check("ovf_after3", 64'(bus.overflow), 64'd1);
        check("full_after3", 64'(bus.full), 64'd1);
        check("hold_sum", 64'(bus.outSum), 64'd1);
        rdy = 1'b1;
        repeat (4) idle();
        check("drained_outValid", 64'(bus.outValid), 64'd0);
        check("drained_model", 64'(expQ.size()), 64'd0);

        // Reset with a buffered record and a partial burst outstanding.
        rdy = 1'b0;
        drive(1'b1, 32'd9, 3'd3, 12'h006, 1'b1);
        drive(1'b1, 32'd10, 3'd0, 12'h007, 1'b0);
        drive(1'b1, 32'd11, 3'd1, 12'h007, 1'b0);
        resetDut();
        check("post_rst_outValid", 64'(bus.outValid), 64'd0);
        drive(1'b1, 32'd7, 3'd4, 12'h008, 1'b1);
        idle();
        check("post_rst_sum", 64'(bus.outSum), 64'd7);
        check("post_rst_mask", 64'(bus.outSeenMask), 64'h10);
        check("post_rst_ovf", 64'(bus.overflow), 64'd0);
        rdy = 1'b1;
        repeat (2) idle();

        // Randomized bursts, random backpressure, occasional protocol errors.
        for (int b = 0; b < 200; b++) begin
            len = $urandom_range(1, 6);
            for (int k = 0; k < 6; k++) p[k] = k;
            for (int k = 5; k > 0; k--) begin
                j    = $urandom_range(0, k);
                t    = p[k];
                p[k] = p[j];
                p[j] = t;
            end
            tag = EW'($urandom);
            for (int k = 0; k < len; k++) begin
                idx = 3'(p[k]);
                if ($urandom_range(0, 7) == 0) idx = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 11) == 0) tag = EW'($urandom);
                rdy = ($urandom_range(0, 3) != 0);
                drive(1'b1, RW'($urandom), idx, tag, k == len - 1);
            end
            t = $urandom_range(0, 2);
            for (int k = 0; k < t; k++) begin
                rdy = ($urandom_range(0, 3) != 0);
                idle();
            end
        end

        rdy = 1'b1;
        for (int k = 0; k < 20 && expQ.size() > 0; k++) idle();
        idle();
        check("final_drain", 64'(expQ.size()), 64'd0);
        check("final_outValid", 64'(bus.outValid), 64'd0);
        check("final_overflow", 64'(bus.overflow), 64'(modelOvf));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
